// File: rtl/ct_f_spsram_512x52_ctrl.sv
// Request/response controller for a 512x52 single-port SRAM with half-word write masks.
// Optional power-up clear sweep of the whole array is compiled in with SPSRAM_CTRL_INIT_EN.
module ct_f_spsram_512x52_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [8:0]  req_addr,
  input  logic [51:0] req_wdata,
  input  logic [1:0]  req_wmask,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [51:0] rsp_rdata,
  output logic        init_done,
  output logic        sram_cen,
  output logic        sram_gwen,
  output logic [51:0] sram_wen,
  output logic [8:0]  sram_a,
  output logic [51:0] sram_d,
  input  logic [51:0] sram_q
);

`ifdef SPSRAM_CTRL_INIT_EN
  typedef enum logic [1:0] {RST_ST = 2'd0, INIT = 2'd1, RUN = 2'd2} state_t;
  logic [8:0] cnt_q, cnt_d;
  logic       in_init;
`else
  typedef enum logic [1:0] {RST_ST = 2'd0, RUN = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        init_done_q, init_done_d;
  logic [8:0]  a_q;
  logic [51:0] d_q;
  logic        acc;

  // State register: control only; address/data hold registers carry no reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RST_ST;
      rsp_vld_q   <= 1'b0;
      init_done_q <= 1'b0;
`ifdef SPSRAM_CTRL_INIT_EN
      cnt_q       <= 9'd0;
`endif
    end else begin
      state_q     <= state_d;
      rsp_vld_q   <= rsp_vld_d;
      init_done_q <= init_done_d;
`ifdef SPSRAM_CTRL_INIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    a_q <= sram_a;
    d_q <= sram_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef SPSRAM_CTRL_INIT_EN
      RST_ST:  state_d = INIT;
      INIT:    if (cnt_q == 9'd511) state_d = RUN;
`else
      RST_ST:  state_d = RUN;
`endif
      RUN:     state_d = RUN;
      default: state_d = RST_ST;
    endcase
  end

  // Output logic; RST gates every SRAM strobe even while state_q still shows the old state
  always_comb begin
    req_rdy   = !RST && (state_q == RUN) && (!rsp_vld_q || rsp_rdy);
    acc       = req_vld && req_rdy;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = a_q;
    sram_d    = d_q;
`ifdef SPSRAM_CTRL_INIT_EN
    in_init   = !RST && (state_q == INIT);
    cnt_d     = (state_q == INIT) ? cnt_q + 9'd1 : cnt_q;
    if (in_init) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt_q;
      sram_d    = '0;
    end else
`endif
    if (acc) begin
      sram_cen  = 1'b0;
      sram_gwen = !req_wr;
      sram_wen  = req_wr ? {{26{!req_wmask[1]}}, {26{!req_wmask[0]}}} : '1;
      sram_a    = req_addr;
      sram_d    = req_wdata;
    end
    // A new read accepted in the same cycle as the handshake keeps the response valid
    rsp_vld_d   = (acc && !req_wr) || (rsp_vld_q && !rsp_rdy);
    init_done_d = init_done_q || (state_d == RUN);
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = sram_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ct_f_spsram_512x52_ctrl.sv
// Randomized bench for ct_f_spsram_512x52_ctrl against an entry-level memory model.
// Works with and without SPSRAM_CTRL_INIT_EN.
module tb_ct_f_spsram_512x52_ctrl;
  logic        CLK = 1'b0;
  logic        RST;
  logic        req_vld, req_rdy, req_wr;
  logic [8:0]  req_addr;
  logic [51:0] req_wdata;
  logic [1:0]  req_wmask;
  logic        rsp_vld, rsp_rdy;
  logic [51:0] rsp_rdata;
  logic        init_done, sram_cen, sram_gwen;
  logic [51:0] sram_wen, sram_d, sram_q;
  logic [8:0]  sram_a;

  int n_vec = 0;
  int n_err = 0;

  logic [51:0] mem     [512];
  logic [51:0] ref_mem [512];
  logic [51:0] pend_q  [$];
  bit          exp_run;
  bit          last_known;
  logic [8:0]  last_a;
  logic [51:0] last_d;
  localparam logic [51:0] ONES = '1;

  always #5 CLK = ~CLK;

  ct_f_spsram_512x52_ctrl dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // SRAM macro: bit-masked write, registered read, output held when not enabled
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus with full pin-level checks against the model
  task automatic cyc(input bit vld, input bit wr, input logic [8:0] addr,
                     input logic [51:0] wd, input logic [1:0] wm, input bit rdy);
    bit          exp_rdy, acc;
    logic [51:0] exp_wen;
    req_vld = vld; req_wr = wr; req_addr = addr; req_wdata = wd; req_wmask = wm; rsp_rdy = rdy;
    @(negedge CLK);
    exp_rdy = exp_run && (pend_q.size() == 0 || rdy);
    acc     = vld && exp_rdy;
    check_eq("init_done", init_done, exp_run);
    check_eq("req_rdy", req_rdy, exp_rdy);
    check_eq("rsp_vld", rsp_vld, pend_q.size() != 0);
    if (pend_q.size() != 0) check_eq("rsp_rdata", rsp_rdata, pend_q[0]);
    if (acc) begin
      exp_wen = ONES;
      if (wr && wm[0]) exp_wen[25:0]  = '0;
      if (wr && wm[1]) exp_wen[51:26] = '0;
      check_eq("acc_cen", sram_cen, 0);
      check_eq("acc_gwen", sram_gwen, !wr);
      check_eq("acc_wen", sram_wen, exp_wen);
      check_eq("acc_a", sram_a, addr);
      check_eq("acc_d", sram_d, wd);
      if (wr && wm[0]) ref_mem[addr][25:0]  = wd[25:0];
      if (wr && wm[1]) ref_mem[addr][51:26] = wd[51:26];
      last_a = addr; last_d = wd; last_known = 1;
    end else begin
      check_eq("idle_cen", sram_cen, 1);
      check_eq("idle_gwen", sram_gwen, 1);
      check_eq("idle_wen", sram_wen, ONES);
      if (last_known) begin
        check_eq("idle_a", sram_a, last_a);
        check_eq("idle_d", sram_d, last_d);
      end
    end
    if (pend_q.size() != 0 && rdy) void'(pend_q.pop_front());
    if (acc && !wr) pend_q.push_back(ref_mem[addr]);
    @(posedge CLK); #1;
  endtask

  // Hold RST for ncyc cycles, then run the one RST_ST cycle after release
  task automatic do_reset(input int ncyc);
    RST = 1'b1; req_vld = 1'b1; req_wr = 1'b0; rsp_rdy = 1'b1;
    repeat (ncyc) begin
      @(negedge CLK);
      check_eq("rst_cen", sram_cen, 1);
      check_eq("rst_gwen", sram_gwen, 1);
      check_eq("rst_wen", sram_wen, ONES);
      check_eq("rst_req_rdy", req_rdy, 0);
      @(posedge CLK); #1;
      check_eq("rst_rsp_vld", rsp_vld, 0);
      check_eq("rst_init_done", init_done, 0);
    end
    RST = 1'b0;
    exp_run = 0; pend_q.delete(); last_known = 0;
    cyc(1, 0, 9'h000, '0, 2'b00, 1);
  endtask

`ifdef SPSRAM_CTRL_INIT_EN
  task automatic init_sweep(input int stop_at);
    req_vld = 1'b1; req_wr = 1'b0; rsp_rdy = 1'b1;
    for (int i = 0; i <= stop_at && i < 512; i++) begin
      @(negedge CLK);
      check_eq("init_cen", sram_cen, 0);
      check_eq("init_gwen", sram_gwen, 0);
      check_eq("init_wen", sram_wen, 0);
      check_eq("init_a", sram_a, i);
      check_eq("init_d", sram_d, 0);
      check_eq("init_req_rdy", req_rdy, 0);
      check_eq("init_done_low", init_done, 0);
      @(posedge CLK); #1;
    end
    if (stop_at >= 511) begin
      for (int k = 0; k < 512; k++) ref_mem[k] = '0;
      exp_run = 1; last_a = 9'h1FF; last_d = '0; last_known = 1;
    end
  endtask
`endif

  initial begin
    logic [63:0] rnd;
    logic [51:0] wd0, exp_d, first;
    for (int k = 0; k < 512; k++) begin
      rnd = {$urandom, $urandom};
      mem[k] = rnd[51:0];
      ref_mem[k] = rnd[51:0];
    end
    sram_q = '0;
    do_reset(3);
`ifdef SPSRAM_CTRL_INIT_EN
    init_sweep(200);
    do_reset(2);
    init_sweep(511);
    cyc(1, 0, 9'h1FF, '0, 2'b00, 1);
    check_eq("init_rd_vld", rsp_vld, 1);
    check_eq("init_rd_data", rsp_rdata, 0);
`else
    exp_run = 1;
    cyc(1, 0, 9'h1FF, '0, 2'b00, 1);
    check_eq("first_rd_vld", rsp_vld, 1);
`endif
    // Full-word write then read-back
    wd0 = 52'hA_BCDE_F012_3456;
    cyc(1, 1, 9'h005, wd0, 2'b11, 1);
    cyc(1, 0, 9'h005, '0, 2'b00, 1);
    check_eq("wr_rd_vld", rsp_vld, 1);
    check_eq("wr_rd_data", rsp_rdata, wd0);
    // Low half-word only
    cyc(1, 1, 9'h005, ONES, 2'b01, 1);
    cyc(1, 0, 9'h005, '0, 2'b00, 1);
    exp_d = wd0;
    exp_d[25:0] = '1;
    check_eq("mask_rd_data", rsp_rdata, exp_d);
    // Zero-mask write is a no-op
    cyc(1, 1, 9'h005, '0, 2'b00, 1);
    cyc(1, 0, 9'h005, '0, 2'b00, 1);
    check_eq("nomask_rd_data", rsp_rdata, exp_d);
    // Back-to-back reads with a stalled first response
    cyc(1, 0, 9'h010, '0, 2'b00, 1);
    first = rsp_rdata;
    repeat (3) begin
      cyc(1, 0, 9'h011, '0, 2'b00, 0);
      check_eq("stall_rdata", rsp_rdata, first);
    end
    cyc(1, 0, 9'h011, '0, 2'b00, 1);
    cyc(1, 0, 9'h012, '0, 2'b00, 1);
    cyc(0, 0, 9'h000, '0, 2'b00, 1);
    cyc(0, 0, 9'h000, '0, 2'b00, 1);
    // Reset with a response pending
    cyc(1, 0, 9'h033, '0, 2'b00, 0);
    do_reset(2);
`ifdef SPSRAM_CTRL_INIT_EN
    init_sweep(511);
`else
    exp_run = 1;
`endif
    for (int n = 0; n < 1500; n++) begin
      rnd = {$urandom, $urandom};
      cyc(($urandom % 4) != 0, $urandom % 2,
          ($urandom % 2) ? 9'($urandom % 16) : 9'($urandom % 512),
          rnd[51:0], 2'($urandom % 4), ($urandom % 4) != 0);
    end
    cyc(0, 0, 9'h000, '0, 2'b00, 1);
    cyc(0, 0, 9'h000, '0, 2'b00, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
